// File: rtl/sha3_seq_pkg.sv
// Shared definitions for the slice-serial round sequencer: controller states
// and the write-source code that selects the host input path.
package sha3_seq_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD       = 4'd1,
        S_WAIT_RDY = 4'd2,
        S_START    = 4'd3,
        S_WAIT_REQ = 4'd4,
        S_FEED     = 4'd5,
        S_WAIT_OUT = 4'd6,
        S_WB       = 4'd7,
        NEXT       = 4'd8,
        INFORM     = 4'd9,
        RESULT     = 4'd10
    } seq_state_t;

    localparam int MEM_SRC_HOST = 0;

endpackage

// File: rtl/sha3_next_stage_pick.sv
// Finds the next enabled stage in a mask: either the lowest set bit at or
// above cur (inclusive=1) or strictly above cur (inclusive=0).
module sha3_next_stage_pick #(
    parameter int NUM_STAGES = 5,
    parameter int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic [NUM_STAGES-1:0] mask,
    input  logic [IDX_W-1:0]      cur,
    input  logic                  inclusive,
    output logic [IDX_W-1:0]      idx,
    output logic                  none
);

    // Priority search from stage 0 upward; the first qualifying stage wins.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (none && mask[i] &&
                ((i > int'(cur)) || (inclusive && (i == int'(cur))))) begin
                idx  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sha3_round_sequencer.sv
// Round sequencer for the slice-serial permutation core. Loads the state from
// the host, then for each round walks the enabled step units in ascending
// order (wait ready, start, stream slices in, wait result, write back), and
// finally streams the result out. All outputs are decoded from state.
module sha3_round_sequencer
    import sha3_seq_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int SLICES     = 64,
    parameter int ROUND_W    = 5,
    parameter int SLICE_W    = $clog2(SLICES),
    parameter int SRC_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROUND_W-1:0]    rounds,
    input  logic [NUM_STAGES-1:0] stage_mask,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stg_ready,
    input  logic [NUM_STAGES-1:0] stg_req_in,
    input  logic [NUM_STAGES-1:0] stg_out_valid,
    output logic [NUM_STAGES-1:0] stg_start,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [SLICE_W-1:0]    mem_addr,
    output logic [SRC_W-1:0]      mem_src,
    output logic                  ready,
    output logic                  put_input,
    output logic                  out_ready,
    output logic                  done,
    output logic [ROUND_W-1:0]    round_idx,
    output logic                  busy
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    seq_state_t              state;
    logic [SLICE_W-1:0]      slice_cnt;
    logic [IDX_W-1:0]        ptr;
    logic [ROUND_W-1:0]      round_q;
    logic [ROUND_W-1:0]      rounds_q;
    logic [NUM_STAGES-1:0]   mask_q;
    logic                    done_q;

    logic                    last_slice;
    logic [ROUND_W-1:0]      round_next;
    logic [SLICE_W-1:0]      slice_next;
    logic [IDX_W-1:0]        lowest_idx;
    logic                    lowest_none;
    logic [IDX_W-1:0]        above_idx;
    logic                    above_none;

    assign last_slice = (slice_cnt == SLICE_W'(SLICES - 1));
    assign slice_next = last_slice ? '0 : slice_cnt + SLICE_W'(1);
    assign round_next = round_q + ROUND_W'(1);

    sha3_next_stage_pick #(
        .NUM_STAGES(NUM_STAGES),
        .IDX_W     (IDX_W)
    ) u_pick_lowest (
        .mask     (mask_q),
        .cur      ('0),
        .inclusive(1'b1),
        .idx      (lowest_idx),
        .none     (lowest_none)
    );

    sha3_next_stage_pick #(
        .NUM_STAGES(NUM_STAGES),
        .IDX_W     (IDX_W)
    ) u_pick_above (
        .mask     (mask_q),
        .cur      (ptr),
        .inclusive(1'b0),
        .idx      (above_idx),
        .none     (above_none)
    );

    // Controller state, slice/round counters and the one-cycle done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            slice_cnt <= '0;
            ptr       <= '0;
            round_q   <= '0;
            rounds_q  <= '0;
            mask_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                slice_cnt <= '0;
                ptr       <= '0;
                round_q   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rounds_q  <= rounds;
                            mask_q    <= stage_mask;
                            slice_cnt <= '0;
                            ptr       <= '0;
                            round_q   <= '0;
                            state     <= LOAD;
                        end
                    end
                    LOAD: begin
                        slice_cnt <= slice_next;
                        if (last_slice) begin
                            if ((rounds_q == '0) || lowest_none) begin
                                state <= INFORM;
                            end else begin
                                ptr   <= lowest_idx;
                                state <= S_WAIT_RDY;
                            end
                        end
                    end
                    S_WAIT_RDY: begin
                        if (stg_ready[ptr]) state <= S_START;
                    end
                    S_START: begin
                        slice_cnt <= '0;
                        state     <= S_WAIT_REQ;
                    end
                    S_WAIT_REQ: begin
                        if (stg_req_in[ptr]) state <= S_FEED;
                    end
                    S_FEED: begin
                        slice_cnt <= slice_next;
                        if (last_slice) state <= S_WAIT_OUT;
                    end
                    S_WAIT_OUT: begin
                        if (stg_out_valid[ptr]) state <= S_WB;
                    end
                    S_WB: begin
                        slice_cnt <= slice_next;
                        if (last_slice) state <= NEXT;
                    end
                    NEXT: begin
                        if (!above_none) begin
                            ptr   <= above_idx;
                            state <= S_WAIT_RDY;
                        end else begin
                            round_q <= round_next;
                            if (round_next == rounds_q) begin
                                state <= INFORM;
                            end else begin
                                ptr   <= lowest_idx;
                                state <= S_WAIT_RDY;
                            end
                        end
                    end
                    INFORM: begin
                        slice_cnt <= '0;
                        state     <= RESULT;
                    end
                    RESULT: begin
                        slice_cnt <= slice_next;
                        if (last_slice) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign put_input = (state == LOAD);
    assign mem_wr    = (state == LOAD) || (state == S_WB);
    assign mem_rd    = (state == S_FEED) || (state == RESULT);
    assign mem_addr  = slice_cnt;
    assign mem_src   = (state == S_WB) ? (SRC_W'(ptr) + SRC_W'(1))
                                       : SRC_W'(MEM_SRC_HOST);
    assign out_ready = (state == INFORM);
    assign stg_start = (state == S_START) ? (NUM_STAGES'(1) << ptr) : '0;
    assign done      = done_q;
    assign round_idx = round_q;

endmodule

// File: tb/tb_sha3_round_sequencer.sv
// Self-checking bench for sha3_round_sequencer. A responder plays the step
// units; a monitor compresses the strobe activity into an event log (bursts,
// stage starts, out_ready, done) that is compared with a log derived directly
// from the round/mask rules.
module tb_sha3_round_sequencer;

    localparam int NS   = 5;
    localparam int SL   = 4;
    localparam int RW   = 5;
    localparam int SW   = 2;
    localparam int SRCW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [RW-1:0]   rounds;
    logic [NS-1:0]   stage_mask;
    logic            abort;
    logic [NS-1:0]   stg_ready;
    logic [NS-1:0]   stg_req_in;
    logic [NS-1:0]   stg_out_valid;
    logic [NS-1:0]   stg_start;
    logic            mem_rd;
    logic            mem_wr;
    logic [SW-1:0]   mem_addr;
    logic [SRCW-1:0] mem_src;
    logic            ready;
    logic            put_input;
    logic            out_ready;
    logic            done;
    logic [RW-1:0]   round_idx;
    logic            busy;

    sha3_round_sequencer #(
        .NUM_STAGES(NS),
        .SLICES    (SL),
        .ROUND_W   (RW),
        .SLICE_W   (SW),
        .SRC_W     (SRCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rounds       (rounds),
        .stage_mask   (stage_mask),
        .abort        (abort),
        .stg_ready    (stg_ready),
        .stg_req_in   (stg_req_in),
        .stg_out_valid(stg_out_valid),
        .stg_start    (stg_start),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_src      (mem_src),
        .ready        (ready),
        .put_input    (put_input),
        .out_ready    (out_ready),
        .done         (done),
        .round_idx    (round_idx),
        .busy         (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Event codes: type<<16 | field<<8 | value
    // 1 = write burst (src, length), 2 = read burst (length),
    // 3 = stage start (round, stage), 4 = out_ready, 5 = done (round_idx)
    int obsQ[$];
    int expQ[$];
    int curType, curSrc, curLen;
    int act, reqWait, readsSeen, ovWait, wbLen;
    bit reqOn, ovOn, fastMode;
    int stallStage, stallLen;
    int wrTotal, rdTotal, doneCount;
    logic [NS-1:0] drvReady, drvReq, drvOv;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        obsQ.delete();
        curType = 0; curSrc = 0; curLen = 0;
        act = -1; reqWait = 0; readsSeen = 0; ovWait = 0; wbLen = 0;
        reqOn = 1'b0; ovOn = 1'b0;
        wrTotal = 0; rdTotal = 0; doneCount = 0;
    endtask

    task automatic closeBurst();
        if (curType != 0) obsQ.push_back((curType << 16) | (curSrc << 8) | curLen);
        curType = 0;
        curLen  = 0;
    endtask

    // One clock: sample outputs at the falling edge, update the event log and
    // step-unit model, then drive the next step-unit inputs.
    task automatic tick();
        int typ, src, idx;
        logic [NS-1:0] noise, actBit;
        @(negedge clk);
        if (mem_rd && mem_wr) checkOutput("rdWrOverlap", 32'd1, 32'd0);
        typ = mem_wr ? 1 : (mem_rd ? 2 : 0);
        src = mem_wr ? int'(mem_src) : 0;
        if (typ != curType || src != curSrc || curLen == SL) closeBurst();
        if (typ != 0) begin
            if (curType == 0) begin
                curType = typ;
                curSrc  = src;
                curLen  = 0;
            end
            checkOutput("memAddr", 32'(mem_addr), 32'(curLen));
            curLen++;
        end
        wrTotal += int'(mem_wr);
        rdTotal += int'(mem_rd);
        if (stg_start != '0) begin
            checkOutput("startOneHot", 32'($onehot(stg_start)), 32'd1);
            idx = 0;
            for (int k = 0; k < NS; k++) if (stg_start[k]) idx = k;
            checkOutput("startReady", 32'(drvReady[idx]), 32'd1);
            obsQ.push_back((3 << 16) | (int'(round_idx) << 8) | idx);
            act = idx; readsSeen = 0; wbLen = 0; reqOn = 1'b0; ovOn = 1'b0;
            reqWait = fastMode ? 0 : int'($urandom_range(0, 2));
            ovWait  = (idx == stallStage) ? stallLen
                    : (fastMode ? 1 : int'($urandom_range(1, 3)));
        end
        if (out_ready) obsQ.push_back(4 << 16);
        if (done) begin
            obsQ.push_back((5 << 16) | (int'(round_idx) << 8));
            doneCount++;
        end
        if (act >= 0) begin
            if (mem_rd && readsSeen == 0) checkOutput("reqGate", 32'(drvReq[act]), 32'd1);
            if (readsSeen == SL && wbLen == 0) begin
                checkOutput("wbTiming", 32'(mem_wr), 32'(drvOv[act]));
                if (!drvOv[act]) checkOutput("waitOutRead", 32'(mem_rd), 32'd0);
            end
            if (readsSeen == SL && !ovOn) begin
                ovWait--;
                if (ovWait <= 0) ovOn = 1'b1;
            end
            if (!reqOn && readsSeen == 0) begin
                if (reqWait == 0) reqOn = 1'b1;
                else reqWait--;
            end
            if (mem_rd) begin
                readsSeen++;
                reqOn = 1'b0;
            end
            if (mem_wr) wbLen++;
            if (wbLen == SL) begin
                act  = -1;
                ovOn = 1'b0;
            end
        end
        actBit   = (act >= 0) ? (NS'(1) << act) : '0;
        drvReady = fastMode ? '1 : (NS'($urandom) | NS'($urandom));
        noise    = NS'($urandom);
        drvReq   = (noise & ~actBit) | (reqOn ? actBit : '0);
        noise    = NS'($urandom);
        drvOv    = (noise & ~actBit) | (ovOn ? actBit : '0);
        stg_ready     = drvReady;
        stg_req_in    = drvReq;
        stg_out_valid = drvOv;
    endtask

    // Expected event log: host load, then every enabled stage in ascending
    // order for every round, then out_ready, result read and done.
    task automatic buildExpected(input int r, input int m);
        bit runs;
        expQ.delete();
        runs = (r != 0) && (m != 0);
        expQ.push_back((1 << 16) | SL);
        if (runs) begin
            for (int rr = 0; rr < r; rr++) begin
                for (int k = 0; k < NS; k++) begin
                    if (((m >> k) & 1) == 1) begin
                        expQ.push_back((3 << 16) | (rr << 8) | k);
                        expQ.push_back((2 << 16) | SL);
                        expQ.push_back((1 << 16) | ((k + 1) << 8) | SL);
                    end
                end
            end
        end
        expQ.push_back(4 << 16);
        expQ.push_back((2 << 16) | SL);
        expQ.push_back((5 << 16) | ((runs ? r : 0) << 8));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"},     32'(ready),     32'd1);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_memRd"},     32'(mem_rd),    32'd0);
        checkOutput({tag, "_memWr"},     32'(mem_wr),    32'd0);
        checkOutput({tag, "_memAddr"},   32'(mem_addr),  32'd0);
        checkOutput({tag, "_memSrc"},    32'(mem_src),   32'd0);
        checkOutput({tag, "_putInput"},  32'(put_input), 32'd0);
        checkOutput({tag, "_outReady"},  32'(out_ready), 32'd0);
        checkOutput({tag, "_done"},      32'(done),      32'd0);
        checkOutput({tag, "_roundIdx"},  32'(round_idx), 32'd0);
        checkOutput({tag, "_stgStart"},  32'(stg_start), 32'd0);
    endtask

    // Launch one run, follow it to done (bounded), and compare its event log.
    task automatic applyStimulus(input int r, input int m, input bit pokeStart);
        int cyc;
        resetModel();
        rounds     = RW'(r);
        stage_mask = NS'(m);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        rounds     = RW'($urandom);
        stage_mask = NS'($urandom);
        cyc = 0;
        while (doneCount == 0 && cyc < 3000) begin
            tick();
            cyc++;
            start = pokeStart && (cyc == 20) && (doneCount == 0);
        end
        start = 1'b0;
        checkOutput("runReachedDone", 32'(doneCount != 0), 32'd1);
        repeat (3) tick();
        checkOutput("doneCount", 32'(doneCount), 32'd1);
        buildExpected(r, m);
        checkOutput("eventCount", 32'(obsQ.size()), 32'(expQ.size()));
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            checkOutput($sformatf("event%0d_r%0d_m%0d", i, r, m), 32'(obsQ[i]), 32'(expQ[i]));
            if (obsQ[i] != expQ[i]) break;
        end
    endtask

    // Hard stop if the bench itself gets stuck.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized runs.
    initial begin
        int cyc;
        int starts[NS];
        rst = 1'b1; start = 1'b0; rounds = '0; stage_mask = '0; abort = 1'b0;
        stg_ready = '0; stg_req_in = '0; stg_out_valid = '0;
        drvReady = '0; drvReq = '0; drvOv = '0;
        stallStage = -1; stallLen = 0; fastMode = 1'b1;
        resetModel();
        #3;
        checkResetOutputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full chain, one round, immediate responses.
        applyStimulus(1, 5'b11111, 1'b0);
        checkOutput("fullWrTotal", 32'(wrTotal), 32'd24);
        checkOutput("fullRdTotal", 32'(rdTotal), 32'd24);

        // Sparse mask, three rounds.
        applyStimulus(3, 5'b00101, 1'b0);
        for (int k = 0; k < NS; k++) starts[k] = 0;
        foreach (obsQ[i]) if ((obsQ[i] >> 16) == 3) starts[obsQ[i] & 255]++;
        for (int k = 0; k < NS; k++)
            checkOutput($sformatf("startsStage%0d", k), 32'(starts[k]), (k == 0 || k == 2) ? 32'd3 : 32'd0);

        // Nothing to do: zero rounds, then empty mask.
        applyStimulus(0, 5'b11111, 1'b0);
        checkOutput("zeroRoundsWr", 32'(wrTotal), 32'd4);
        checkOutput("zeroRoundsRd", 32'(rdTotal), 32'd4);
        applyStimulus(2, 5'b00000, 1'b0);
        checkOutput("emptyMaskWr", 32'(wrTotal), 32'd4);
        checkOutput("emptyMaskRd", 32'(rdTotal), 32'd4);

        // Stage 1 holds its result back for ten cycles.
        stallStage = 1; stallLen = 10;
        applyStimulus(1, 5'b11111, 1'b0);
        stallStage = -1;

        // Abort in the middle of feeding stage 2.
        resetModel();
        rounds = 5'd1; stage_mask = 5'b11111; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(act == 2 && readsSeen == 2) && cyc < 500) begin
            tick();
            cyc++;
        end
        checkOutput("abortReachedFeed", 32'(act == 2 && readsSeen == 2), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortReady",    32'(ready),     32'd1);
        checkOutput("abortBusy",     32'(busy),      32'd0);
        checkOutput("abortMemRd",    32'(mem_rd),    32'd0);
        checkOutput("abortMemWr",    32'(mem_wr),    32'd0);
        checkOutput("abortDone",     32'(done),      32'd0);
        checkOutput("abortRoundIdx", 32'(round_idx), 32'd0);
        repeat (4) tick();
        checkOutput("abortNoDone", 32'(doneCount), 32'd0);
        applyStimulus(1, 5'b10110, 1'b0);

        // Asynchronous reset during a write-back.
        resetModel();
        rounds = 5'd2; stage_mask = 5'b11111; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(mem_wr && mem_src != '0) && cyc < 500) begin
            tick();
            cyc++;
        end
        checkOutput("rstReachedWb", 32'(mem_wr && mem_src != '0), 32'd1);
        #2 rst = 1'b1;
        #1 checkResetOutputs("asyncRst");
        tick();
        rst = 1'b0;
        resetModel();

        // Start pulsed mid-run must not disturb the run in progress.
        applyStimulus(2, 5'b01011, 1'b1);

        // Randomized runs with random step-unit latencies.
        fastMode = 1'b0;
        for (int i = 0; i < 8; i++)
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), i == 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
